// File: rtl/tick_scheduler_pkg.sv
// Shared types and constants for the tick scheduler: channel states, mode encoding
// and parameter defaults.
package tick_scheduler_pkg;

   typedef enum logic {
      CH_IDLE = 1'b0,
      CH_RUN  = 1'b1
   } ch_state_e;

   localparam int unsigned DEFAULT_PW       = 16;
   localparam int unsigned DEFAULT_PRESCALE = 100;

   localparam logic MODE_PERIODIC = 1'b0;
   localparam logic MODE_ONESHOT  = 1'b1;

   // Channel-select width; a single channel still gets a 1-bit selector.
   function automatic int unsigned ch_width(input int unsigned num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage

// File: rtl/tick_scheduler_if.sv
// Configuration channel of the tick scheduler: valid/ready handshake plus the
// per-request channel programming payload.
interface tick_scheduler_if
   import tick_scheduler_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned PW     = DEFAULT_PW
);
   localparam int unsigned CW = ch_width(NUM_CH);

   logic          cfg_valid;
   logic          cfg_ready;
   logic [CW-1:0] cfg_ch;
   logic          cfg_enable;
   logic          cfg_oneshot;
   logic [PW-1:0] cfg_period;

   modport master (
      output cfg_valid,
      output cfg_ch,
      output cfg_enable,
      output cfg_oneshot,
      output cfg_period,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_ch,
      input  cfg_enable,
      input  cfg_oneshot,
      input  cfg_period,
      output cfg_ready
   );

endinterface

// File: rtl/tick_prescaler.sv
// Free-running base-tick divider: base_tick is high for one clk100MHz cycle out of
// every PRESCALE.
module tick_prescaler
   import tick_scheduler_pkg::*;
#(
   parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
   input  logic clk100MHz,
   input  logic rst_n,
   output logic base_tick
);
   localparam int unsigned   CNTW = $clog2(PRESCALE);
   localparam logic [CNTW-1:0] LAST = CNTW'(PRESCALE - 1);

   logic [CNTW-1:0] pre_cnt_q;
   logic [CNTW-1:0] pre_cnt_d;

   assign base_tick = (pre_cnt_q == LAST);

   always_comb begin
      pre_cnt_d = pre_cnt_q + CNTW'(1);
      if (base_tick) begin
         pre_cnt_d = '0;
      end
   end

   always_ff @(posedge clk100MHz or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt_q <= '0;
      end else begin
         pre_cnt_q <= pre_cnt_d;
      end
   end

endmodule

// File: rtl/tick_scheduler.sv
// Shared time-base scheduler: one prescaler feeding NUM_CH independent countdown
// channels that emit single-cycle clock-enable pulses.
module tick_scheduler
   import tick_scheduler_pkg::*;
#(
   parameter int unsigned NUM_CH   = 4,
   parameter int unsigned PRESCALE = DEFAULT_PRESCALE,
   parameter int unsigned PW       = DEFAULT_PW
) (
   input  logic              clk100MHz,
   input  logic              rst_n,
   tick_scheduler_if.slave   cfg,
   output logic              base_tick,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] active
);
   localparam int unsigned CW = ch_width(NUM_CH);

   logic cfg_fire;
   logic cfg_start;

   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk100MHz (clk100MHz),
      .rst_n     (rst_n),
      .base_tick (base_tick)
   );

   // Config is refused on base-tick cycles so it never races a countdown update.
   assign cfg.cfg_ready = ~base_tick;
   assign cfg_fire      = cfg.cfg_valid & ~base_tick;
   assign cfg_start     = cfg.cfg_enable & (cfg.cfg_period != '0);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      ch_state_e     state_q;
      logic [PW-1:0] remaining_q;
      logic [PW-1:0] period_q;
      logic          oneshot_q;
      logic          tick_q;
      logic          sel;

      // Out-of-range channel numbers simply match no channel.
      assign sel = cfg_fire & (cfg.cfg_ch == CW'(i));

      always_ff @(posedge clk100MHz or negedge rst_n) begin
         if (!rst_n) begin
            state_q     <= CH_IDLE;
            remaining_q <= '0;
            period_q    <= '0;
            oneshot_q   <= MODE_PERIODIC;
            tick_q      <= 1'b0;
         end else begin
            tick_q <= 1'b0;
            if (sel) begin
               if (cfg_start) begin
                  state_q     <= CH_RUN;
                  remaining_q <= cfg.cfg_period;
                  period_q    <= cfg.cfg_period;
                  oneshot_q   <= cfg.cfg_oneshot;
               end else begin
                  state_q     <= CH_IDLE;
                  remaining_q <= '0;
               end
            end else if (base_tick && (state_q == CH_RUN)) begin
               if (remaining_q > PW'(1)) begin
                  remaining_q <= remaining_q - PW'(1);
               end else begin
                  tick_q <= 1'b1;
                  if (oneshot_q == MODE_ONESHOT) begin
                     state_q     <= CH_IDLE;
                     remaining_q <= '0;
                  end else begin
                     remaining_q <= period_q;
                  end
               end
            end
         end
      end

      assign tick[i]   = tick_q;
      assign active[i] = (state_q == CH_RUN);
   end

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler: directed vector tables, hand sequences for
// reconfiguration and async reset, and random traffic against a cycle-time model.
module tb_tick_scheduler;
   import tick_scheduler_pkg::*;

   localparam int P   = 4;
   localparam int NCH = 4;

   logic clk100MHz = 1'b0;
   logic rst_n     = 1'b0;
   always #5 clk100MHz = ~clk100MHz;

   tick_scheduler_if #(.NUM_CH(NCH), .PW(16)) cif ();
   tick_scheduler_if #(.NUM_CH(3),   .PW(16)) cif3 ();

   logic           base_tick;
   logic [NCH-1:0] tick;
   logic [NCH-1:0] active;
   logic           base_tick3;
   logic [2:0]     tick3;
   logic [2:0]     active3;

   tick_scheduler #(.NUM_CH(NCH), .PRESCALE(P), .PW(16)) dut (
      .clk100MHz (clk100MHz),
      .rst_n     (rst_n),
      .cfg       (cif),
      .base_tick (base_tick),
      .tick      (tick),
      .active    (active)
   );

   tick_scheduler #(.NUM_CH(3), .PRESCALE(P), .PW(16)) dut3 (
      .clk100MHz (clk100MHz),
      .rst_n     (rst_n),
      .cfg       (cif3),
      .base_tick (base_tick3),
      .tick      (tick3),
      .active    (active3)
   );

   typedef struct {
      int cyc;
      int ch;
      bit en;
      bit os;
      int period;
   } cfg_vec_t;

   typedef struct {
      int         cyc;
      logic [3:0] tick;
      logic [3:0] active;
      bit         base;
      bit         ready;
   } exp_vec_t;

   cfg_vec_t cfg_tab[3];
   exp_vec_t exp_tab[15];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit use_tab  = 1'b0;
   bit last_acc = 1'b0;

   // Model: each running channel knows the absolute cycle of its next pulse.
   bit m_run  [NCH];
   int m_next [NCH];
   int m_per  [NCH];
   bit m_os   [NCH];
   int m_from [NCH];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int c = 0; c < NCH; c++) begin
         m_run[c]  = 1'b0;
         m_next[c] = 0;
         m_per[c]  = 0;
         m_os[c]   = 1'b0;
         m_from[c] = 0;
      end
   endtask

   task automatic model_accept(input int ch, input bit en, input bit os, input int per);
      int b1;
      if (en && per != 0) begin
         b1 = cyc + ((P - 1) - (cyc % P));
         if (b1 == cyc) b1 += P;
         m_run[ch]  = 1'b1;
         m_next[ch] = b1 + (per - 1) * P + 1;
         m_per[ch]  = per;
         m_os[ch]   = os;
         m_from[ch] = cyc + 1;
      end else begin
         m_run[ch] = 1'b0;
      end
   endtask

   // Checks the current cycle against the model, applies any handshake, then advances.
   task automatic run_cycle();
      bit             eb;
      bit             acc;
      logic [NCH-1:0] et;
      logic [NCH-1:0] ea;
      eb = (cyc % P) == (P - 1);
      for (int c = 0; c < NCH; c++) begin
         et[c] = m_run[c] && (cyc == m_next[c]);
         if (et[c]) begin
            if (m_os[c]) m_run[c] = 1'b0;
            else         m_next[c] += m_per[c] * P;
         end
         ea[c] = m_run[c] && (cyc >= m_from[c]);
      end
      chk("base_tick", base_tick, eb);
      chk("cfg_ready", cif.cfg_ready, !eb);
      chk("tick", tick, et);
      chk("active", active, ea);
      if (use_tab) begin
         foreach (exp_tab[i]) begin
            if (exp_tab[i].cyc == cyc) begin
               chk("tab_tick", tick, exp_tab[i].tick);
               chk("tab_active", active, exp_tab[i].active);
               chk("tab_base", base_tick, exp_tab[i].base);
               chk("tab_ready", cif.cfg_ready, exp_tab[i].ready);
            end
         end
      end
      acc = cif.cfg_valid && !eb;
      if (acc) begin
         model_accept(int'(cif.cfg_ch), cif.cfg_enable, cif.cfg_oneshot, int'(cif.cfg_period));
      end
      last_acc = acc;
      @(posedge clk100MHz);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      repeat (n) run_cycle();
   endtask

   // Holds the request until the handshake completes (at most two cycles).
   task automatic cfg_write(input int ch, input bit en, input bit os, input int per);
      bit done;
      done             = 1'b0;
      cif.cfg_valid    = 1'b1;
      cif.cfg_ch       = 2'(ch);
      cif.cfg_enable   = en;
      cif.cfg_oneshot  = os;
      cif.cfg_period   = 16'(per);
      for (int k = 0; k < 4 && !done; k++) begin
         run_cycle();
         done = last_acc;
      end
      cif.cfg_valid = 1'b0;
   endtask

   task automatic align_ready();
      while ((cyc % P) == (P - 1)) run_cycle();
   endtask

   task automatic cfg3_pulse(input int ch, input bit en, input int per);
      align_ready();
      cif3.cfg_valid  = 1'b1;
      cif3.cfg_ch     = 2'(ch);
      cif3.cfg_enable = en;
      cif3.cfg_period = 16'(per);
      run_cycle();
      cif3.cfg_valid  = 1'b0;
   endtask

   task automatic release_reset();
      @(posedge clk100MHz);
      #1;
      rst_n = 1'b1;
      cyc   = 0;
      model_clear();
   endtask

   initial begin
      cfg_tab[0] = '{1, 0, 1'b1, 1'b0, 3};
      cfg_tab[1] = '{4, 2, 1'b1, 1'b1, 1};
      cfg_tab[2] = '{7, 3, 1'b1, 1'b0, 2};

      exp_tab[0]  = '{0,  4'b0000, 4'b0000, 1'b0, 1'b1};
      exp_tab[1]  = '{2,  4'b0000, 4'b0001, 1'b0, 1'b1};
      exp_tab[2]  = '{3,  4'b0000, 4'b0001, 1'b1, 1'b0};
      exp_tab[3]  = '{4,  4'b0000, 4'b0001, 1'b0, 1'b1};
      exp_tab[4]  = '{5,  4'b0000, 4'b0101, 1'b0, 1'b1};
      exp_tab[5]  = '{7,  4'b0000, 4'b0101, 1'b1, 1'b0};
      exp_tab[6]  = '{8,  4'b0100, 4'b0001, 1'b0, 1'b1};
      exp_tab[7]  = '{9,  4'b0000, 4'b1001, 1'b0, 1'b1};
      exp_tab[8]  = '{11, 4'b0000, 4'b1001, 1'b1, 1'b0};
      exp_tab[9]  = '{12, 4'b0001, 4'b1001, 1'b0, 1'b1};
      exp_tab[10] = '{16, 4'b1000, 4'b1001, 1'b0, 1'b1};
      exp_tab[11] = '{20, 4'b0000, 4'b1001, 1'b0, 1'b1};
      exp_tab[12] = '{24, 4'b1001, 4'b1001, 1'b0, 1'b1};
      exp_tab[13] = '{32, 4'b1000, 4'b1001, 1'b0, 1'b1};
      exp_tab[14] = '{36, 4'b0001, 4'b1001, 1'b0, 1'b1};

      cif.cfg_valid   = 1'b0;
      cif.cfg_ch      = '0;
      cif.cfg_enable  = 1'b0;
      cif.cfg_oneshot = 1'b0;
      cif.cfg_period  = '0;
      cif3.cfg_valid   = 1'b0;
      cif3.cfg_ch      = '0;
      cif3.cfg_enable  = 1'b0;
      cif3.cfg_oneshot = 1'b0;
      cif3.cfg_period  = '0;
      model_clear();

      repeat (2) @(posedge clk100MHz);
      release_reset();

      // Reset, periodic, one-shot and handshake-stall scenarios.
      use_tab = 1'b1;
      foreach (cfg_tab[i]) begin
         while (cyc < cfg_tab[i].cyc) run_cycle();
         cfg_write(cfg_tab[i].ch, cfg_tab[i].en, cfg_tab[i].os, cfg_tab[i].period);
      end
      while (cyc <= 40) run_cycle();
      use_tab = 1'b0;

      // Reconfiguration mid-count, then stop via period 0.
      cfg_write(1, 1'b1, 1'b0, 5);
      idle(9);
      cfg_write(1, 1'b1, 1'b0, 1);
      idle(10);
      cfg_write(1, 1'b1, 1'b0, 0);
      idle(12);
      chk("ch1_stopped", active[1], 1'b0);

      // Out-of-range channel on a three-channel instance.
      cfg3_pulse(2, 1'b1, 1);
      idle(5);
      chk("dut3_ch2_run", active3, 3'b100);
      cfg3_pulse(3, 1'b0, 0);
      idle(6);
      chk("dut3_oor_stop", active3, 3'b100);
      cfg3_pulse(3, 1'b1, 1);
      for (int k = 0; k < 8; k++) begin
         chk("dut3_oor_tick", tick3[1:0], 2'b00);
         chk("dut3_oor_act", active3, 3'b100);
         run_cycle();
      end

      // Asynchronous reset between edges with ch0 and ch3 running.
      chk("pre_reset_act", active, 4'b1001);
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst_tick", tick, 4'b0000);
      chk("rst_active", active, 4'b0000);
      chk("rst_base", base_tick, 1'b0);
      chk("rst_ready", cif.cfg_ready, 1'b1);
      chk("rst_active3", active3, 3'b000);
      @(posedge clk100MHz);
      #1;
      chk("rst_hold_act", active, 4'b0000);
      release_reset();
      idle(24);

      // Random traffic against the model.
      repeat (800) begin
         if (!cif.cfg_valid && $urandom_range(0, 5) == 0) begin
            cif.cfg_valid   = 1'b1;
            cif.cfg_ch      = 2'($urandom_range(0, NCH - 1));
            cif.cfg_enable  = ($urandom_range(0, 7) != 0);
            cif.cfg_oneshot = $urandom_range(0, 1) == 1;
            cif.cfg_period  = 16'($urandom_range(0, 4));
         end
         run_cycle();
         if (last_acc) cif.cfg_valid = 1'b0;
      end
      cif.cfg_valid = 1'b0;
      idle(30);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Shared time-base scheduler that derives a 1 µs base tick from the 100 MHz board clock. It sequences NUM_CH independent channels, each producing single-cycle enable pulses at a programmed period, either periodic or one-shot. It replaces per-consumer free-running dividers in the lab top levels, such as the display scan, debounce sampling and the slow processor step. Consumers use the pulses as clock enables on clk100MHz; no derived clocks are generated.

## Interface

Parameters:
- NUM_CH, 4: number of channels (1..8).
- PRESCALE, 100: clk100MHz cycles per base tick (≥ 2).
- PW, 16: channel period width, in base ticks.

Ports:
- clk100MHz  in  1  system clock; the only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accept; a transfer occurs when cfg_valid & cfg_ready.
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel.
- cfg_enable  in  1  1 = start/restart, 0 = stop.
- cfg_oneshot  in  1  1 = fire once then stop, 0 = periodic.
- cfg_period  in  PW  period in base ticks.
- base_tick  out  1  high one cycle every PRESCALE cycles.
- tick  out  NUM_CH  per-channel single-cycle pulse.
- active  out  NUM_CH  channel in RUN.

## Operation

- **Prescaler:**
  - pre_cnt counts 0..PRESCALE-1 and wraps.
  - It is free-running from reset and is never cleared by config.
  - base_tick = (pre_cnt == PRESCALE-1), combinational from the register.
- **Per-channel FSM**, states IDLE and RUN. Per-channel registers: remaining[PW], period[PW], oneshot.
- **Accepted config** with cfg_enable=1 and cfg_period≠0:
  - Load period and remaining from cfg_period, latch oneshot.
  - Go to RUN, even if the channel was already in RUN. The old countdown is discarded and no pending tick is issued.
- **Accepted config** with cfg_enable=0 or cfg_period=0: go to IDLE and set remaining to 0.
- **Out-of-range cfg_ch** (≥ NUM_CH): accepted and ignored.
- **Clock edge with base_tick=1, channel in RUN:**
  - If remaining > 1: decrement.
  - If remaining == 1: set tick[ch] on the next cycle. Then reload remaining from period if periodic; if oneshot, go to IDLE.
- **Handshake:**
  - cfg_ready = ~base_tick, so config never coincides with a countdown update.
  - The requester holds cfg_valid and its payload until accepted.
  - At most one config is accepted per cycle.
- **Reset:** asynchronous and immediate.
  - pre_cnt=0; all channels IDLE with remaining=0, period=0 and oneshot=0.
  - tick=0, active=0, base_tick=0, cfg_ready=1.
- Arithmetic is unsigned. remaining never underflows: IDLE channels do not decrement.

## Timing

- base_tick is first high in cycle PRESCALE-1 after rst_n deasserts, then every PRESCALE cycles.
- tick[ch] is registered and high for exactly one cycle, the cycle after the qualifying base_tick edge.
- **Latency**, config accepted in cycle A:
  - The first tick follows the cfg_period-th base_tick strictly after A.
  - Latency is therefore cfg_period·PRESCALE cycles, minus the prescaler phase.
- **Periodic spacing:** exactly period·PRESCALE cycles between pulses.
- active[ch] is registered:
  - It rises in cycle A+1.
  - For a one-shot it falls in the same cycle that tick[ch] is high.
- Multiple channels may tick in the same cycle. They are independent and not arbitrated.

## Structure

- **Package tick_scheduler_pkg:**
  - Channel state enum: CH_IDLE, CH_RUN.
  - Defaults for PW and PRESCALE.
  - Mode constants: MODE_PERIODIC=0, MODE_ONESHOT=1.
- **Sub-module tick_prescaler:**
  - Holds pre_cnt and base_tick.
  - Parameter PRESCALE.
  - Ports clk100MHz and rst_n.
- The channel FSMs are a generate loop in tick_scheduler.

## Test plan

All scenarios use PRESCALE=4 and NUM_CH=4.

1. **Reset.** Deassert rst_n at cycle 0.
   - tick=0, active=0 and cfg_ready=1.
   - base_tick in cycles 3, 7, 11, …; cfg_ready=0 in exactly those cycles.
2. **Periodic.** ch0, period=3, accepted in cycle 1.
   - active[0]=1 from cycle 2.
   - tick[0] in cycles 12, 24, 36; no other tick bits set.
3. **One-shot.** ch2, period=1, oneshot=1, accepted in cycle 4.
   - tick[2] in cycle 8 only.
   - active[2] goes 1→0 in cycle 8 and no further ticks occur.
4. **Handshake stall.** cfg_valid raised in cycle 7 (base_tick high).
   - cfg_ready=0 in cycle 7; accepted in cycle 8.
   - With period=2, first tick in cycle 16.
5. **Reconfiguration.**
   - ch1 running at period=5 is reconfigured to period=1 mid-count. Its next tick follows the first base_tick after acceptance, and no tick is issued for the old period.
   - A later write of period=0 to ch1 sets active[1]=0 with no further ticks.
   - A write with cfg_ch out of range for NUM_CH=3 changes nothing.
6. **Reset mid-operation.** Assert rst_n low asynchronously, between clock edges, with ch0 and ch3 running.
   - All outputs go to reset values immediately.
   - After release, base_tick phase restarts at cycle 3 and no ticks occur until a channel is reconfigured.
